ram_port_arbiter: RTL and testbench
===================================

# ram_port_arbiter

Single-clock, two-requester round-robin arbiter for one port of the team's dual-port RAM (`my_ram_2port`, 10-bit address, 8-bit data). Each requester issues write or read commands with a valid/grant handshake. The block registers the winning command onto the RAM port and routes read data back to its issuer after a fixed latency. It sits between a `ram_control`-style sequencer pair and the RAM. This lets two agents in the same clock domain share port A or port B without collisions.

## Interface
- `AW`, 10, address width
- `DW`, 8, data width
- `RD_LAT`, 2, cycles from `ram_address` being driven to valid `ram_q` (address reg + output reg)

Ports:
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `req0`, `req1`  in  1  command valid; held until granted
- `we0`, `we1`  in  1  1 = write, 0 = read
- `addr0`, `addr1`  in  AW  command address
- `wdata0`, `wdata1`  in  DW  write data
- `gnt0`, `gnt1`  out  1  combinational grant; handshake completes when `reqN & gntN`
- `rvalid0`, `rvalid1`  out  1  one-cycle read-return pulse
- `rdata0`, `rdata1`  out  DW  read data; holds last value between pulses
- `ram_address`  out  AW  to RAM port address
- `ram_data`  out  DW  to RAM port data
- `ram_wren`  out  1  to RAM port write enable
- `ram_q`  in  DW  RAM port read data

## Operation
- At most one grant per cycle.
  - `gntN` depends only on `req0`, `req1` and the registered priority pointer `last`.
  - It never depends on `weN`, `addrN` or `wdataN`.
- With a single request, that request is granted every cycle, so back-to-back commands run at full rate.
- With both requests, the requester not granted most recently wins.
  - `last` updates only on a completed handshake.
  - Maximum wait under contention is 1 cycle.
- Reset value of `last` is 1, so requester 0 wins the first contention.
- Granted command registers onto the RAM port in the next cycle:
  - `ram_address` ← `addrN`
  - `ram_data` ← `wdataN`
  - `ram_wren` ← `weN`
- With no grant, `ram_wren` = 0; `ram_address` and `ram_data` hold their values.
- Return pipeline: a shift register of depth `RD_LAT`+1 carries {valid, id} for each granted read. Writes insert valid = 0.
- On pipeline exit, `rdataN` ← `ram_q` and `rvalidN` pulses for the matching id only.
- Commands take effect at the RAM in grant order. A read granted after a write to the same address returns the new data, which relies on RAM read-during-write being outside the same cycle.
- Reset values: `ram_address` = 0, `ram_data` = 0, `ram_wren` = 0, `rvalid*` = 0, `rdata*` = 0, pipeline valids = 0.
- Reset mid-operation: in-flight reads are discarded. No `rvalid` pulses for pre-reset reads. Pending requests are re-arbitrated from `last` = 1.
- A requester that deasserts `reqN` before grant is legal; that command is simply not issued.

## Timing
- Cycle T: handshake (`reqN & gntN`).
- T+1: `ram_*` outputs carry the command.
- T+1+`RD_LAT`: `ram_q` valid at the RAM.
- T+2+`RD_LAT`: `rvalidN` = 1 and `rdataN` valid (default T+4).
- Read throughput: 1 per cycle aggregate. Returns stay in grant order across both requesters.
- Write: RAM is written at the clock edge ending cycle T+1. There is no acknowledge beyond `gntN`.

## Structure
- Package `ram_arb_pkg` holds:
  - default `AW`/`DW`/`RD_LAT` constants
  - a 1-bit requester id typedef
  - a packed command struct {we, addr, wdata}
  - a return-tag struct {valid, id}
- Sub-module `rr_arb2`: combinational two-way round-robin picker plus the `last` register. Inputs: `req0`, `req1`, `fire`. Outputs: `gnt0`, `gnt1`.
- The top holds the command mux/register, the tag shift register and the return demux.

## Test plan
- Reset: hold `rst_n` = 0 with random requests. Every output is 0, and `gnt*` follows the arbitration rule with `last` = 1.
- Single requester: req0 writes 10'h005 = 8'hA5, then reads 10'h005. `ram_wren` = 1 for one cycle, `rvalid0` pulses at read-grant + 4 with `rdata0` = 8'hA5, and `rvalid1` stays 0.
- Contention: both hold reads of 10'h001 (0) and 10'h002 (1) for 6 cycles after reset. Grants go 0,1,0,1,0,1, and returns alternate with the preloaded values.
- Back-to-back: req1 reads addresses 0–3 consecutively, preloaded 8'h10..8'h13. `rvalid1` is high 4 consecutive cycles with 8'h10, 8'h11, 8'h12, 8'h13.
- Write/read ordering: req1 writes 10'h3FF = 8'h5A in the cycle req0 reads 10'h3FF, with `last` = 0. Requester 1 is granted first, so `rdata0` = 8'h5A.
- Reset mid-flight: assert `rst_n` = 0 one cycle after granting two reads. No `rvalid` ever pulses for them, and post-reset traffic behaves as in the single-requester test.

Source files
------------

// File: rtl/ram_arb_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | ram_arb_pkg                                                             |
// | Shared widths, requester id, command and return-tag types for the       |
// | two-requester RAM port arbiter.                                         |
// | Revision: 1.0                                                           |
// +-------------------------------------------------------------------------+
package ram_arb_pkg;

    localparam int C_AW     = 10;
    localparam int C_DW     = 8;
    localparam int C_RD_LAT = 2;

    typedef logic req_id_t;

    typedef struct packed {
        logic            we;
        logic [C_AW-1:0] addr;
        logic [C_DW-1:0] wdata;
    } ram_cmd_t;

    typedef struct packed {
        logic    valid;
        req_id_t id;
    } ret_tag_t;

    function automatic ram_cmd_t make_cmd(input logic            we,
                                          input logic [C_AW-1:0] addr,
                                          input logic [C_DW-1:0] wdata);
        ram_cmd_t c;
        c.we    = we;
        c.addr  = addr;
        c.wdata = wdata;
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | rr_arb2                                                                 |
// | Two-way round-robin picker; grants depend only on requests and last.    |
// | Revision: 1.0                                                           |
// +-------------------------------------------------------------------------+
module rr_arb2
    import ram_arb_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic req0,
    input  logic req1,
    input  logic fire,
    output logic gnt0,
    output logic gnt1
);

    req_id_t r_last;
    logic    w_gnt0;
    logic    w_gnt1;

    // Under contention the requester not granted most recently wins.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (req0 && req1) begin
            if (r_last == 1'b1) begin
                w_gnt0 = 1'b1;
            end else begin
                w_gnt1 = 1'b1;
            end
        end else begin
            w_gnt0 = req0;
            w_gnt1 = req1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= 1'b1;
        end else if (fire) begin
            r_last <= w_gnt1;
        end
    end

    assign gnt0 = w_gnt0;
    assign gnt1 = w_gnt1;

endmodule
`default_nettype wire

// File: rtl/ram_port_arbiter.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | ram_port_arbiter                                                        |
// | Shares one RAM port between two requesters and routes read data back.   |
// | Revision: 1.0                                                           |
// +-------------------------------------------------------------------------+
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int AW     = C_AW,
    parameter int DW     = C_DW,
    parameter int RD_LAT = C_RD_LAT
)
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic [AW-1:0] ram_address,
    output logic [DW-1:0] ram_data,
    output logic          ram_wren,
    input  logic [DW-1:0] ram_q
);

    logic          w_gnt0;
    logic          w_gnt1;
    logic          w_fire;
    req_id_t       w_sel;
    ram_cmd_t      w_cmd;
    ret_tag_t      w_exit;

    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_data;
    logic          r_wren;
    ret_tag_t      r_tag [RD_LAT+1];
    logic          r_rvalid0;
    logic          r_rvalid1;
    logic [DW-1:0] r_rdata0;
    logic [DW-1:0] r_rdata1;

    rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req0  (req0),
        .req1  (req1),
        .fire  (w_fire),
        .gnt0  (w_gnt0),
        .gnt1  (w_gnt1)
    );

    assign w_fire = (req0 & w_gnt0) | (req1 & w_gnt1);
    assign w_sel  = w_gnt1;

    always_comb begin
        w_cmd = make_cmd(we0, addr0, wdata0);
        if (w_sel) begin
            w_cmd = make_cmd(we1, addr1, wdata1);
        end
    end

    // Address and data hold when idle so the RAM sees no spurious toggles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr <= '0;
            r_data <= '0;
            r_wren <= 1'b0;
        end else begin
            r_wren <= w_fire & w_cmd.we;
            if (w_fire) begin
                r_addr <= w_cmd.addr;
                r_data <= w_cmd.wdata;
            end
        end
    end

    // One stage per cycle from grant to ram_q being valid at the RAM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i <= RD_LAT; i++) begin
                r_tag[i] <= '0;
            end
        end else begin
            r_tag[0].valid <= w_fire & ~w_cmd.we;
            r_tag[0].id    <= w_sel;
            for (int i = 1; i <= RD_LAT; i++) begin
                r_tag[i] <= r_tag[i-1];
            end
        end
    end

    assign w_exit = r_tag[RD_LAT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
            r_rdata0  <= '0;
            r_rdata1  <= '0;
        end else begin
            r_rvalid0 <= w_exit.valid & (w_exit.id == 1'b0);
            r_rvalid1 <= w_exit.valid & (w_exit.id == 1'b1);
            if (w_exit.valid && (w_exit.id == 1'b0)) begin
                r_rdata0 <= ram_q;
            end
            if (w_exit.valid && (w_exit.id == 1'b1)) begin
                r_rdata1 <= ram_q;
            end
        end
    end

    assign gnt0        = w_gnt0;
    assign gnt1        = w_gnt1;
    assign ram_address = r_addr;
    assign ram_data    = r_data;
    assign ram_wren    = r_wren;
    assign rvalid0     = r_rvalid0;
    assign rvalid1     = r_rvalid1;
    assign rdata0      = r_rdata0;
    assign rdata1      = r_rdata1;

endmodule
`default_nettype wire

// File: tb/tb_ram_port_arbiter.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | tb_ram_port_arbiter                                                     |
// | Directed bench with a RAM model and a read-return scoreboard.           |
// | Revision: 1.0                                                           |
// +-------------------------------------------------------------------------+
module tb_ram_port_arbiter;

    localparam int AW = 10;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req0 = 1'b0, req1 = 1'b0;
    logic          we0 = 1'b0, we1 = 1'b0;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic [DW-1:0] wdata0 = '0, wdata1 = '0;
    logic          gnt0, gnt1, rvalid0, rvalid1, ram_wren;
    logic [DW-1:0] rdata0, rdata1, ram_data;
    logic [AW-1:0] ram_address;
    logic [DW-1:0] ram_q = '0;

    ram_port_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1),
        .ram_address(ram_address), .ram_data(ram_data), .ram_wren(ram_wren),
        .ram_q(ram_q)
    );

    always #5 clk = ~clk;

    // RAM: registered address, registered output (2-cycle read latency).
    logic [DW-1:0] mem [1024];
    logic [AW-1:0] m_addr = '0;
    always @(posedge clk) begin
        if (ram_wren) mem[ram_address] <= ram_data;
        m_addr <= ram_address;
        ram_q  <= mem[m_addr];
    end

    typedef struct {
        logic          id;
        logic [DW-1:0] data;
        int            due;
    } sb_t;

    sb_t           sb [$];
    logic [DW-1:0] exp_mem [1024];
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    logic          exp_last = 1'b1;
    logic          pend_v = 1'b0, pend_we = 1'b0;
    logic [AW-1:0] pend_addr = '0, exp_addr = '0;
    logic [DW-1:0] pend_data = '0, exp_data = '0;
    logic [DW-1:0] exp_rd0 = '0, exp_rd1 = '0;
    logic          exp_wren = 1'b0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    task automatic step();
        logic eg0, eg1, ev0, ev1, id;
        sb_t  e;
        @(negedge clk);
        exp_wren = 1'b0;
        if (pend_v) begin
            exp_wren = pend_we;
            exp_addr = pend_addr;
            exp_data = pend_data;
        end
        chk("ram_wren", {15'd0, ram_wren}, {15'd0, exp_wren});
        chk("ram_address", {6'd0, ram_address}, {6'd0, exp_addr});
        chk("ram_data", {8'd0, ram_data}, {8'd0, exp_data});
        ev0 = 1'b0;
        ev1 = 1'b0;
        if (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            if (e.id) begin ev1 = 1'b1; exp_rd1 = e.data; end
            else      begin ev0 = 1'b1; exp_rd0 = e.data; end
        end
        chk("rvalid0", {15'd0, rvalid0}, {15'd0, ev0});
        chk("rvalid1", {15'd0, rvalid1}, {15'd0, ev1});
        chk("rdata0", {8'd0, rdata0}, {8'd0, exp_rd0});
        chk("rdata1", {8'd0, rdata1}, {8'd0, exp_rd1});
        eg0 = req0 & (~req1 | exp_last);
        eg1 = req1 & (~req0 | ~exp_last);
        chk("gnt0", {15'd0, gnt0}, {15'd0, eg0});
        chk("gnt1", {15'd0, gnt1}, {15'd0, eg1});
        pend_v = 1'b0;
        if (rst_n && (eg0 || eg1)) begin
            id        = eg1;
            exp_last  = id;
            pend_v    = 1'b1;
            pend_we   = id ? we1 : we0;
            pend_addr = id ? addr1 : addr0;
            pend_data = id ? wdata1 : wdata0;
            if (pend_we) exp_mem[pend_addr] = pend_data;
            else sb.push_back('{id: id, data: exp_mem[pend_addr], due: cyc + 4});
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic do_reset(input int n);
        rst_n    = 1'b0;
        sb.delete();
        exp_last = 1'b1;
        pend_v   = 1'b0;
        exp_addr = '0;
        exp_data = '0;
        exp_rd0  = '0;
        exp_rd1  = '0;
        repeat (n) step();
        req0  = 1'b0;
        req1  = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic idle(input int n);
        req0 = 1'b0;
        req1 = 1'b0;
        repeat (n) step();
    endtask

    task automatic set0(input logic r, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req0 = r; we0 = w; addr0 = a; wdata0 = d;
    endtask

    task automatic set1(input logic r, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req1 = r; we1 = w; addr1 = a; wdata1 = d;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) exp_mem[i] = '0;
        #1;
        // Reset held with random traffic: outputs stay 0, grants follow last = 1.
        rst_n = 1'b0;
        for (int i = 0; i < 6; i++) begin
            set0(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 10'($urandom), 8'($urandom));
            set1(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 10'($urandom), 8'($urandom));
            if (i == 0) begin set0(1'b1, 1'b0, 10'h0, 8'h0); set1(1'b1, 1'b0, 10'h0, 8'h0); end
            do_reset(1);
            rst_n = 1'b0;
        end
        do_reset(1);

        // Preload addresses 0..3 with 8'h10..8'h13 through requester 0.
        for (int i = 0; i < 4; i++) begin
            set0(1'b1, 1'b1, 10'(i), 8'(8'h10 + i));
            step();
        end
        idle(2);

        // Single requester: write then read back.
        set0(1'b1, 1'b1, 10'h005, 8'hA5);
        step();
        set0(1'b1, 1'b0, 10'h005, 8'h00);
        step();
        idle(6);

        // Back-to-back reads from requester 1.
        for (int i = 0; i < 4; i++) begin
            set1(1'b1, 1'b0, 10'(i), 8'h00);
            step();
        end
        idle(6);

        // Contention straight after reset: grants alternate 0,1,0,1,0,1.
        do_reset(1);
        set0(1'b1, 1'b0, 10'h001, 8'h00);
        set1(1'b1, 1'b0, 10'h002, 8'h00);
        repeat (6) step();
        idle(6);

        // Write/read ordering with last = 0: requester 1's write wins first.
        set0(1'b1, 1'b0, 10'h000, 8'h00);
        step();
        set0(1'b1, 1'b0, 10'h3FF, 8'h00);
        set1(1'b1, 1'b1, 10'h3FF, 8'h5A);
        step();
        req1 = 1'b0;
        step();
        idle(6);
        chk("rdata0_3ff", {8'd0, rdata0}, 16'h005A);

        // Reset one cycle after two reads are granted: their returns vanish.
        set0(1'b1, 1'b0, 10'h001, 8'h00);
        set1(1'b1, 1'b0, 10'h002, 8'h00);
        repeat (2) step();
        idle(1);
        do_reset(2);
        idle(6);
        set0(1'b1, 1'b1, 10'h005, 8'hC3);
        step();
        set0(1'b1, 1'b0, 10'h005, 8'h00);
        step();
        idle(6);
        chk("rdata0_post_reset", {8'd0, rdata0}, 16'h00C3);
        chk("scoreboard_drained", 16'(sb.size()), 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
